// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - LSU data-memory bus controller with req/gnt/rvalid handshake and timeout
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  // core side
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [1:0]  core_size_i,
  input  logic        core_unsigned_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_ready_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  // memory side
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Last counter value a transaction may spend in REQ+WAIT before being aborted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  // Bus-side registered outputs
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Fields of the accepted request needed to shape the response
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;

  // Core-side registered outputs and timeout counter
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request decode and response extraction
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic        timeout_hit;

  assign timeout_hit  = (cnt_q == CNT_LAST);
  assign core_ready_o = (state_q == ST_IDLE);

  // Alignment check of the incoming request against its access size
  always_comb begin
    misaligned = 1'b0;
    case (core_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = core_addr_i[0];
      2'b10:   misaligned = |core_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated write data; loads put zero on the write bus
  always_comb begin
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    case (core_size_i)
      2'b00: begin
        req_be    = 4'b0001 << core_addr_i[1:0];
        req_wdata = {4{core_wdata_i[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << core_addr_i[1:0];
        req_wdata = {2{core_wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = core_wdata_i;
      end
    endcase
    if (!core_we_i) begin
      req_wdata = 32'h0;
    end
  end

  // Lane selection and sign/zero extension of the returned read word
  always_comb begin
    rd_byte = mem_rdata_i[7:0];
    case (off_q)
      2'd0:    rd_byte = mem_rdata_i[7:0];
      2'd1:    rd_byte = mem_rdata_i[15:8];
      2'd2:    rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response arriving on the timeout cycle still completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i && !misaligned) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timeout_hit) begin
          state_d = ST_IDLE;
        end else if (mem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: latch request, drive bus, shape response pulses
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = {core_addr_i[31:2], 2'b00};
            mem_we_d    = core_we_i;
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            we_d        = core_we_i;
            size_d      = core_size_i;
            uns_d       = core_unsigned_i;
            off_d       = core_addr_i[1:0];
            cnt_d       = '0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
        end else if (mem_gnt_i) begin
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : load_data;
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a behavioural access model
module tb_lsu_mem_ctrl;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [1:0]  core_size_i = 2'b00;
  logic        core_unsigned_i = 1'b0;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wdata_i = 32'h0;
  logic        core_ready_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_unsigned_i(core_unsigned_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_ready_o(core_ready_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [31:0] rdata;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'd3) return 1'b1;
    n = 1 << sz;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    logic [3:0] b;
    n = 1 << sz;
    off = int'(a[1:0]);
    b = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wdata(input bit we, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [31:0] r;
    if (!we) return 32'h0;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input bit we, input logic [1:0] sz, input bit uns,
                                            input logic [31:0] a, input logic [31:0] rd);
    int n, off;
    logic [31:0] v, mask;
    if (we) return 32'h0;
    n = 1 << sz;
    off = int'(a[1:0]);
    v = rd >> (8 * off);
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset && (core_rvalid_o || core_err_o)) begin
      chk("rvalid_err_exclusive", 32'(core_rvalid_o & core_err_o), 32'h0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: rvalid=%b err=%b with nothing outstanding (t=%0t)",
                 core_rvalid_o, core_err_o, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_is_err", 32'(core_err_o), 32'(e.is_err));
        if (!e.is_err) last_rd = e.rdata;
        chk("core_rdata", core_rdata_o, last_rd);
        chk("resp_cycle", cyc, e.exp_cyc);
      end
    end
  end

  // ---------------- driver / memory responder ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bus(input logic [31:0] a, input bit we, input logic [3:0] be, input logic [31:0] wd);
    chk("mem_req_held", 32'(mem_req_o), 32'h1);
    chk("mem_addr", mem_addr_o, a & ~32'h3);
    chk("mem_we", 32'(mem_we_o), 32'(we));
    chk("mem_be", 32'(mem_be_o), 32'(be));
    chk("mem_wdata", mem_wdata_o, wd);
    chk("ready_busy", 32'(core_ready_o), 32'h0);
  endtask

  // g: cycles gnt is withheld; r: idle cycles between gnt and rvalid
  task automatic run_txn(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r, input bit no_gnt);
    exp_t e;
    bit mis;
    logic [3:0] be;
    logic [31:0] wexp;
    mis  = is_mis(sz, a);
    be   = exp_be(sz, a);
    wexp = exp_wdata(we, sz, wd);
    chk("ready_before_req", 32'(core_ready_o), 32'h1);
    e.is_err = mis || no_gnt;
    e.rdata  = exp_rdata(we, sz, uns, a, rd);
    if (mis)         e.exp_cyc = cyc + 1;
    else if (no_gnt) e.exp_cyc = cyc + 1 + T;
    else             e.exp_cyc = cyc + 3 + g + r;
    sb.push_back(e);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_unsigned_i = uns;
    core_addr_i = a; core_wdata_i = wd;
    step();
    core_req_i = 1'b0; core_we_i = 1'($urandom()); core_size_i = 2'($urandom());
    core_unsigned_i = 1'($urandom()); core_addr_i = $urandom(); core_wdata_i = $urandom();
    if (mis) begin
      chk("mis_no_mem_req", 32'(mem_req_o), 32'h0);
      chk("mis_ready", 32'(core_ready_o), 32'h1);
      step();
      chk("mis_no_mem_req_later", 32'(mem_req_o), 32'h0);
      return;
    end
    chk_bus(a, we, be, wexp);
    if (no_gnt) begin
      for (int k = 1; k < T; k++) begin
        step();
        chk("timeout_req_held", 32'(mem_req_o), 32'h1);
      end
      step();
      chk("timeout_req_drop", 32'(mem_req_o), 32'h0);
      chk("timeout_ready", 32'(core_ready_o), 32'h1);
      return;
    end
    for (int k = 0; k < g; k++) begin
      step();
      chk_bus(a, we, be, wexp);
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("req_drop_after_gnt", 32'(mem_req_o), 32'h0);
    repeat (r) step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom();
    chk("ready_after_done", 32'(core_ready_o), 32'h1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          g, r, rmax;
    bit          ng;

    // reset state
    step();
    step();
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_be", 32'(mem_be_o), 32'h0);
    chk("rst_core_rvalid", 32'(core_rvalid_o), 32'h0);
    chk("rst_core_err", 32'(core_err_o), 32'h0);
    chk("rst_core_rdata", core_rdata_o, 32'h0);
    reset = 1'b1;
    step();
    chk("ready_after_reset", 32'(core_ready_o), 32'h1);

    // directed accesses
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
    run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h12345678, 0, 0, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h302, 32'h0, 32'h8001F00F, 5, 2, 1'b0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h400, 32'h0, 32'h00007FFF, 7, T - 2 - 7, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0, 0, 0, 1'b1);

    // reset while waiting for rvalid; the late rvalid must be ignored
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 2'd2; core_addr_i = 32'h300;
    step();
    core_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req_o), 32'h0);
    chk("midrst_mem_addr", mem_addr_o, 32'h0);
    chk("midrst_core_rdata", core_rdata_o, 32'h0);
    chk("midrst_ready", 32'(core_ready_o), 32'h1);
    last_rd = 32'h0;
    step();
    reset = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = $urandom();
    step();
    mem_rvalid_i = 1'b0;
    step();
    chk("stale_rvalid_ignored", 32'(core_rvalid_o), 32'h0);
    chk("stale_ready", 32'(core_ready_o), 32'h1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      g    = int'($urandom_range(0, 6));
      rmax = (T - 2 - g) < 5 ? (T - 2 - g) : 5;
      r    = int'($urandom_range(0, rmax));
      ng   = ($urandom_range(0, 15) == 0);
      run_txn(1'($urandom()), sz, 1'($urandom()), a, $urandom(), $urandom(), g, r, ng);
    end

    repeat (4) step();
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
